round_robin_scheduler: RTL
==========================

ROUND_ROBIN_SCHEDULER -- requirements
Module: round_robin_scheduler

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum cycles one grant is held before forced release (legal range 2..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous, active-low.
REQ-004 Port: enable  input  1  scheduler enable; low forces release and blocks new grants.
REQ-005 Port: req  input  4  per-requester request for the shared resource; level-sensitive.
REQ-006 Port: done  input  1  resource reports current transaction complete; one-cycle pulse.
REQ-007 Port: grant  output  4  one-hot grant to the owning requester; all-zero when no owner.
REQ-008 Port: grant_index  output  2  encoded owner index; 0 when grant is all-zero.
REQ-009 Port: busy  output  1  high exactly while grant is non-zero.
REQ-010 Port: timeout  output  1  one-cycle pulse on forced release by the hold watchdog.

Function
REQ-011 The block SHALL implement two states, IDLE and OWNED, with all outputs registered.
REQ-012 In IDLE with enable=1 and req!=0, the block SHALL select the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4) and enter OWNED at the next edge with grant/grant_index/busy set for that winner.
REQ-013 Grant latency SHALL be one cycle: req sampled at edge N yields grant visible after edge N.
REQ-014 In IDLE with req=0 or enable=0, outputs SHALL remain zero and ptr unchanged.
REQ-015 In OWNED, grant SHALL hold constant regardless of other req bits until a release event.
REQ-016 Release events in OWNED: done=1; req[owner]=0; enable=0; watchdog expiry (REQ-019).
REQ-017 On release by done, req drop or watchdog, the block SHALL clear grant/grant_index/busy, set ptr to owner+1 with wrap 3->0, and return to IDLE at the same edge.
REQ-018 On release by enable=0, the block SHALL clear outputs and return to IDLE with ptr unchanged.
REQ-019 A hold counter SHALL clear on entry to OWNED, increment each OWNED cycle, and at count MAX_HOLD-1 without another release event SHALL force release and pulse timeout for one cycle.
REQ-020 Simultaneous events in one cycle SHALL resolve by priority enable=0 > done > req drop > watchdog; timeout SHALL pulse only when the watchdog is the winning cause.
REQ-021 done in IDLE SHALL be ignored.
REQ-022 After any release, at least one all-zero grant cycle (IDLE) SHALL separate consecutive owners; back-to-back grant without gap is forbidden.
REQ-023 grant SHALL never have more than one bit set.

Reset
REQ-024 On reset low, asynchronously: state=IDLE, ptr=0, hold counter=0, grant=0, grant_index=0, busy=0, timeout=0.
REQ-025 Reset asserted mid-OWNED SHALL drop the grant immediately without a timeout pulse; first arbitration after release SHALL start from ptr=0.
REQ-026 Reset deassertion SHALL take effect at the first clock edge after release; no grant in that same cycle is required.

Configuration
REQ-027 Macro RR_SCHED_WATCHDOG_EN SHALL control the hold watchdog.
REQ-028 With RR_SCHED_WATCHDOG_EN defined, REQ-019 applies and timeout is driven as specified.
REQ-029 Without it, no hold counter is built, ownership lasts until done, req drop or enable=0, and timeout SHALL be tied to 0.

Verification
REQ-030 After reset, enable=1, req=4'b1111, done pulsed one cycle after each grant -> grants in order 0001, 0010, 0100, 1000, 0001, each separated by one zero-grant cycle.
REQ-031 ptr=3 (after owner 2 released), req=4'b0011 -> grant=4'b0001, grant_index=0 (wrap-around).
REQ-032 Watchdog on, MAX_HOLD=16, req=4'b0100 held, no done -> grant=0100 for 16 cycles, then timeout=1 one cycle, grant=0, next grant=0100 after one idle cycle.
REQ-033 Owner 1, done=1 and watchdog expiry in same cycle -> release, timeout stays 0, ptr=2.
REQ-034 Owner 3, enable dropped -> grant=0 next edge, ptr stays 3; enable=1 with req=4'b1001 -> grant=1000.
REQ-035 Owner 2, reset pulsed low mid-cycle -> grant=0 immediately; after release with req=4'b0110 -> grant=0010.

Source files
------------

// File: rtl/round_robin_scheduler.sv
// round_robin_scheduler: four-way round-robin owner arbiter for one shared resource.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   enable       low forces release and blocks new grants
//   req[3:0]     level-sensitive per-requester requests
//   done         one-cycle pulse: current transaction complete
//   grant[3:0]   one-hot owner, zero when idle
//   grant_index  encoded owner, zero when idle
//   busy         high while grant is non-zero
//   timeout      one-cycle pulse on forced release by the hold watchdog
// Define RR_SCHED_WATCHDOG_EN to build the MAX_HOLD watchdog; otherwise timeout is tied low.
module round_robin_scheduler #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_index,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {IDLE, OWNED} state_t;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be within 2..255");
    end

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] idx_q, idx_d;
    logic       busy_q, busy_d;
    logic [1:0] win_idx;
    logic       start, rel_en, rel_rot, rel_wd, rel_any;

    // Descending scan so the lowest offset from ptr is the final (winning) assignment.
    always_comb begin
        win_idx = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_q + 2'(k)]) win_idx = ptr_q + 2'(k);
        end
    end

`ifdef RR_SCHED_WATCHDOG_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;
    logic       timeout_q;
    // Watchdog only wins when no higher-priority release is present in the same cycle.
    assign rel_wd  = (state_q == OWNED) && enable && !done && req[idx_q] && (hold_q == HOLD_LAST);
    assign hold_d  = (state_q == OWNED) ? hold_q + 8'd1 : 8'd0;
    assign timeout = timeout_q;
`else
    assign rel_wd  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        start   = (state_q == IDLE) && enable && (|req);
        rel_en  = (state_q == OWNED) && !enable;
        rel_rot = (state_q == OWNED) && enable && (done || !req[idx_q]);
        rel_any = rel_en || rel_rot || rel_wd;
        state_d = start ? OWNED : rel_any ? IDLE : state_q;
        grant_d = start ? (4'b0001 << win_idx) : rel_any ? 4'b0000 : grant_q;
        idx_d   = start ? win_idx : rel_any ? 2'd0 : idx_q;
        busy_d  = start || (busy_q && !rel_any);
        // Rotation past the owner happens on every release except enable drop.
        ptr_d   = (rel_rot || rel_wd) ? idx_q + 2'd1 : ptr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            grant_q   <= 4'b0000;
            idx_q     <= 2'd0;
            busy_q    <= 1'b0;
`ifdef RR_SCHED_WATCHDOG_EN
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
`ifdef RR_SCHED_WATCHDOG_EN
            hold_q    <= hold_d;
            timeout_q <= rel_wd;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_index = idx_q;
    assign busy        = busy_q;

endmodule
